fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RV64 core. Sits directly upstream of the IF/ID pipeline buffer.
- Owns the 64-bit PC and issues one-outstanding-request reads to instruction memory (variable latency).
- Holds each returned 32-bit instruction with its PC in an output slot and produces the IF/ID write enable.
- Handles stalls from ID and redirects (branch/jump) from later stages, squashing stale fetches.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding reads to instruction memory,
// and holds the returned instruction and its PC in a single output slot for IF/ID.
module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [31:0] nextInstruc,
   output logic [63:0] nextPC,
   output logic        e_write,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] slot_pc_q, slot_pc_d;
   logic        misalign_q, misalign_d;
   logic [31:0] count_q, count_d;
   logic        accept;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      slot_pc_d   = slot_pc_q;
      misalign_d  = 1'b0;

      e_write  = out_valid_q & ~id_stall & ~redirect_valid;
      imem_req = (state_q == StReq) & (~out_valid_q | ~id_stall);
      accept   = imem_req & imem_ready;
      count_d  = count_q + 32'(e_write);

      if (e_write) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StReq: begin
            if (accept) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               instr_d     = imem_rdata;
               slot_pc_d   = pc_q;
               out_valid_d = 1'b1;
               pc_d        = pc_q + 64'd4;
               state_d     = StReq;
            end
         end
         StDrop: begin
            if (imem_rvalid) begin
               state_d = StReq;
            end
         end
         default: state_d = StReq;
      endcase

      // A redirect flushes the slot and retargets the PC; any in-flight response becomes stale.
      if (redirect_valid) begin
         pc_d        = redirect_pc & ~64'h3;
         out_valid_d = 1'b0;
         instr_d     = instr_q;
         slot_pc_d   = slot_pc_q;
         misalign_d  = (redirect_pc[1:0] != 2'b00);
         unique case (state_q)
            StReq:   state_d = accept ? StDrop : StReq;
            StWait:  state_d = imem_rvalid ? StReq : StDrop;
            StDrop:  state_d = imem_rvalid ? StReq : StDrop;
            default: state_d = StReq;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StReq;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         instr_q     <= 32'd0;
         slot_pc_q   <= 64'd0;
         misalign_q  <= 1'b0;
         count_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         slot_pc_q   <= slot_pc_d;
         misalign_q  <= misalign_d;
         count_q     <= count_d;
      end
   end

   assign imem_addr    = pc_q;
   assign nextInstruc  = instr_q;
   assign nextPC       = slot_pc_q;
   assign misalign_err = misalign_q;
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall hold, redirects, misalignment,
// PC wrap and mid-fetch reset.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [31:0] nextInstruc;
   logic [63:0] nextPC;
   logic        e_write;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int tests = 0;
   int fails = 0;

   fetch_stage #(.RESET_PC(64'h1000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .nextInstruc    (nextInstruc),
      .nextPC         (nextPC),
      .e_write        (e_write),
      .misalign_err   (misalign_err),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Issue one fetch from REQ: accept this cycle, respond after lat cycles.
   task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int lat);
      imem_ready = 1'b1;
      settle();
      chk("req_issue", {63'd0, imem_req}, 64'd1);
      chk("req_addr", imem_addr, addr);
      step();
      imem_ready = 1'b0;
      for (int i = 1; i < lat; i++) begin
         settle();
         chk("req_wait", {63'd0, imem_req}, 64'd0);
         step();
      end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      step();
      imem_rvalid = 1'b0;
   endtask

   task automatic check_slot(input logic [63:0] pc, input logic [31:0] instr);
      settle();
      chk("slot_pc", nextPC, pc);
      chk("slot_instr", {32'd0, nextInstruc}, {32'd0, instr});
   endtask

   task automatic redirect(input logic [63:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      settle();
      chk("redir_no_write", {63'd0, e_write}, 64'd0);
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      imem_ready     = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'd0;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      settle();
      chk("rst_req", {63'd0, imem_req}, 64'd1);
      chk("rst_addr", imem_addr, 64'h1000);
      chk("rst_ewrite", {63'd0, e_write}, 64'd0);
      chk("rst_count", {32'd0, fetch_count}, 64'd0);
      chk("rst_nextpc", nextPC, 64'd0);
      chk("rst_instr", {32'd0, nextInstruc}, 64'd0);
      chk("rst_misalign", {63'd0, misalign_err}, 64'd0);

      // Sequential fetch, 1-cycle latency
      fetch(64'h1000, 32'h0000_0013, 1);
      check_slot(64'h1000, 32'h0000_0013);
      chk("seq_ewrite0", {63'd0, e_write}, 64'd1);
      fetch(64'h1004, 32'h0010_0093, 1);
      chk("seq_count1", {32'd0, fetch_count}, 64'd1);
      check_slot(64'h1004, 32'h0010_0093);
      fetch(64'h1008, 32'h0020_0113, 1);
      check_slot(64'h1008, 32'h0020_0113);
      chk("seq_count2", {32'd0, fetch_count}, 64'd2);

      // Stall with full slot for 5 cycles
      id_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_req", {63'd0, imem_req}, 64'd0);
         chk("stall_ewrite", {63'd0, e_write}, 64'd0);
         chk("stall_pc", nextPC, 64'h1008);
         chk("stall_instr", {32'd0, nextInstruc}, 64'h0020_0113);
         step();
      end
      id_stall = 1'b0;
      settle();
      chk("release_ewrite", {63'd0, e_write}, 64'd1);
      fetch(64'h100C, 32'h0030_0193, 1);
      chk("seq_count3", {32'd0, fetch_count}, 64'd3);
      check_slot(64'h100C, 32'h0030_0193);

      // Redirect to 0x2000 flushes 0x100C undelivered
      redirect(64'h2000);
      chk("flush_count", {32'd0, fetch_count}, 64'd3);

      // 0x2000 accepted, redirect one cycle later, 3-cycle latency response dropped
      fetch_drop_start: begin
         imem_ready = 1'b1;
         settle();
         chk("drop_addr", imem_addr, 64'h2000);
         step();
         imem_ready = 1'b0;
         redirect_valid = 1'b1;
         redirect_pc    = 64'h3000;
         settle();
         chk("drop_req0", {63'd0, imem_req}, 64'd0);
         step();
         redirect_valid = 1'b0;
         settle();
         chk("drop_req1", {63'd0, imem_req}, 64'd0);
         step();
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
         settle();
         chk("drop_req2", {63'd0, imem_req}, 64'd0);
         step();
         imem_rvalid = 1'b0;
         settle();
         chk("drop_no_write", {63'd0, e_write}, 64'd0);
      end
      fetch(64'h3000, 32'h0040_0213, 1);
      check_slot(64'h3000, 32'h0040_0213);
      settle();
      chk("tgt_ewrite", {63'd0, e_write}, 64'd1);
      step();
      chk("tgt_count", {32'd0, fetch_count}, 64'd4);

      // Redirect coincident with rvalid of 0x2004
      redirect(64'h2004);
      imem_ready = 1'b1;
      settle();
      chk("coinc_addr", imem_addr, 64'h2004);
      step();
      imem_ready     = 1'b0;
      imem_rvalid    = 1'b1;
      imem_rdata     = 32'h0050_0293;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h5000;
      step();
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      id_stall       = 1'b1;
      settle();
      chk("coinc_empty", {63'd0, imem_req}, 64'd1);
      chk("coinc_ewrite", {63'd0, e_write}, 64'd0);
      chk("coinc_addr5", imem_addr, 64'h5000);
      chk("coinc_count", {32'd0, fetch_count}, 64'd4);
      id_stall = 1'b0;

      // Misaligned redirect
      redirect(64'h4002);
      chk("mis_pulse", {63'd0, misalign_err}, 64'd1);
      chk("mis_addr", imem_addr, 64'h4000);
      step();
      chk("mis_clear", {63'd0, misalign_err}, 64'd0);

      // PC wrap at top of address space
      redirect(64'hFFFF_FFFF_FFFF_FFFC);
      fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313, 2);
      check_slot(64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313);
      chk("wrap_addr", imem_addr, 64'd0);
      chk("wrap_ewrite", {63'd0, e_write}, 64'd1);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      chk("wrap_count", {32'd0, fetch_count}, 64'd5);

      // Reset while waiting; late response must be ignored
      reset = 1'b1;
      step();
      reset       = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0070_0393;
      settle();
      chk("mrst_req", {63'd0, imem_req}, 64'd1);
      chk("mrst_addr", imem_addr, 64'h1000);
      chk("mrst_count", {32'd0, fetch_count}, 64'd0);
      step();
      imem_rvalid = 1'b0;
      id_stall    = 1'b1;
      settle();
      chk("late_empty", {63'd0, imem_req}, 64'd1);
      chk("late_ewrite", {63'd0, e_write}, 64'd0);
      chk("late_nextpc", nextPC, 64'd0);
      chk("late_addr", imem_addr, 64'h1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
